ex_mem_skid_reg: RTL and testbench

Parametrised EX/MEM pipeline boundary, the elastic successor of the fixed EX/MEM register. It carries the WB control, MEM control, ALU result, store data and destination register across the EX/MEM boundary. It adds valid/ready handshaking with a 2-entry skid buffer, so the MEM side can stall without a combinational ready path back into EX. It also adds a flush input that converts everything in flight into bubbles.

---
 rtl/ex_mem_skid_reg_pkg.sv | 9 +
 rtl/pipe_entry.sv | 22 ++
 rtl/ex_mem_skid_reg.sv | 54 +++++
 tb/tb_ex_mem_skid_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_reg_pkg.sv
// ex_mem_skid_reg_pkg: shared EX/MEM boundary widths and memory-control bit positions
package ex_mem_skid_reg_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W = 5;
  localparam int DEF_WB_W = 2;
  localparam int DEF_M_W = 3;
  localparam int MEM_RD_BIT = 0;
  localparam int MEM_WR_BIT = 1;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: valid bit plus payload register with load and clear enables
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         startin,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!startin || clear) begin
      valid <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: elastic EX/MEM pipeline register with 2-entry skid buffer and flush
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W = DEF_RD_W,
  parameter int WB_W = DEF_WB_W,
  parameter int M_W = DEF_M_W
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [WB_W-1:0]   ex_wb,
  input  logic [M_W-1:0]    ex_m,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [WB_W-1:0]   mem_wb,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [RD_W-1:0]   mem_rd,
  output logic [1:0]        occupancy
);
  localparam int P = WB_W + 2 + 2 * DATA_W + RD_W;
  logic [P-1:0] in_p, main_q, skid_q;
  logic main_v, skid_v, accept, drain, unused_m;
  assign unused_m = ^ex_m;
  assign in_p = {ex_wb, ex_m[MEM_RD_BIT], ex_m[MEM_WR_BIT], ex_alu_result, ex_store_data, ex_rd};
  assign ex_ready = startin & ~skid_v;
  assign accept = ex_valid & ex_ready & ~flush;
  assign drain = main_v & mem_ready;
  // main refills from skid when full, otherwise from EX; skid only catches a beat that main cannot take
  pipe_entry #(.W(P)) u_main (
    .clk(clk), .startin(startin),
    .load(~flush & (skid_v ? drain : accept & (~main_v | drain))),
    .clear(flush | (drain & ~skid_v & ~accept)),
    .d(skid_v ? skid_q : in_p), .valid(main_v), .q(main_q)
  );
  pipe_entry #(.W(P)) u_skid (
    .clk(clk), .startin(startin),
    .load(~flush & main_v & ~drain & accept),
    .clear(flush | (skid_v & drain)),
    .d(in_p), .valid(skid_v), .q(skid_q)
  );
  assign mem_valid = main_v;
  assign occupancy = {skid_v, main_v & ~skid_v};
  assign {mem_wb, mem_mem_read, mem_mem_write, mem_alu_result, mem_store_data, mem_rd} = main_v ? main_q : '0;
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: directed and randomized checks against a FIFO queue model
module tb_ex_mem_skid_reg;
  typedef struct packed {
    logic [1:0]  wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
  } beat_t;
  logic clk = 1'b0, startin, flush, ex_valid, ex_ready, mem_valid, mem_ready, mem_mem_read, mem_mem_write;
  logic [1:0] ex_wb, mem_wb, occupancy;
  logic [2:0] ex_m;
  logic [31:0] ex_alu_result, ex_store_data, mem_alu_result, mem_store_data;
  logic [4:0] ex_rd, mem_rd;
  logic [76:0] obs;
  beat_t q[$];
  int vectors = 0, miscompares = 0;
  ex_mem_skid_reg dut (
    .clk(clk), .startin(startin), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wb(ex_wb), .ex_m(ex_m), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wb(mem_wb),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  assign obs = {mem_valid, occupancy, ex_ready, mem_wb, mem_mem_read, mem_mem_write,
                mem_alu_result, mem_store_data, mem_rd};
  function automatic logic [76:0] exp_v();
    beat_t f;
    f = (q.size() != 0) ? q[0] : '0;
    return {q.size() != 0, 2'(q.size()), startin & (q.size() < 2), f};
  endfunction
  task automatic tick();
    bit dr, ac;
    beat_t b;
    b = '{ex_wb, ex_m[0], ex_m[1], ex_alu_result, ex_store_data, ex_rd};
    @(posedge clk);
    dr = q.size() > 0 && mem_ready;
    ac = ex_valid && q.size() < 2 && !flush;
    if (!startin) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (flush) q.delete();
      else if (ac) q.push_back(b);
    end
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] alu, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_alu_result = alu;
    ex_rd = rd;
    ex_store_data = $urandom;
  endtask
  task automatic test_reset();
    startin = 1'b0;
    send(32'h99, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== exp_v() || obs !== 77'd0) begin
        miscompares++;
        $display("FAIL reset[%0d] got %h exp 0", i, obs);
      end
    end
    startin = 1'b1;
    ex_valid = 1'b0;
    tick();
    vectors++;
    if (ex_ready !== 1'b1 || occupancy !== 2'd0 || mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%b occ=%0d v=%b exp rdy=1 occ=0 v=0", ex_ready, occupancy, mem_valid);
    end
  endtask
  task automatic test_streaming();
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'h10 + i, 5'(i + 1));
      tick();
      vectors++;
      if (obs !== exp_v() || mem_alu_result !== 32'h10 + i || mem_rd !== 5'(i + 1) || occupancy !== 2'd1) begin
        miscompares++;
        $display("FAIL stream[%0d] got alu=%h rd=%0d occ=%0d exp alu=%h rd=%0d occ=1", i, mem_alu_result, mem_rd, occupancy, 32'h10 + i, i + 1);
      end
    end
    ex_valid = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_v() || mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end got %h exp %h", obs, exp_v());
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] want[3] = '{32'hA, 32'hB, 32'hC};
    mem_ready = 1'b0;
    send(32'hA, 5'd10);
    tick();
    send(32'hB, 5'd11);
    tick();
    send(32'hC, 5'd12);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== exp_v() || occupancy !== 2'd2 || ex_ready !== 1'b0 || mem_alu_result !== 32'hA) begin
        miscompares++;
        $display("FAIL bp_full[%0d] got occ=%0d rdy=%b alu=%h exp occ=2 rdy=0 alu=a", i, occupancy, ex_ready, mem_alu_result);
      end
    end
    mem_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== exp_v() || mem_valid !== 1'b1 || mem_alu_result !== want[i]) begin
        miscompares++;
        $display("FAIL bp_drain[%0d] got v=%b alu=%h exp v=1 alu=%h", i, mem_valid, mem_alu_result, want[i]);
      end
    end
    ex_valid = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_v() || mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty got %h exp %h", obs, exp_v());
    end
  endtask
  task automatic test_flush_full();
    mem_ready = 1'b0;
    send(32'h1, 5'd1);
    tick();
    send(32'h2, 5'd2);
    tick();
    send(32'hD, 5'd13);
    flush = 1'b1;
    tick();
    vectors++;
    if (obs !== exp_v() || mem_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL flush got v=%b occ=%0d exp v=0 occ=0", mem_valid, occupancy);
    end
    flush = 1'b0;
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== exp_v() || mem_valid !== 1'b0 || mem_alu_result === 32'hD) begin
        miscompares++;
        $display("FAIL flush_after[%0d] got v=%b alu=%h exp v=0", i, mem_valid, mem_alu_result);
      end
    end
  endtask
  task automatic test_bubble();
    mem_ready = 1'b1;
    send(32'h55, 5'd7);
    ex_m = 3'b111;
    ex_wb = 2'b11;
    tick();
    vectors++;
    if (obs !== exp_v() || {mem_valid, mem_mem_read, mem_mem_write, mem_wb} !== 5'b11111) begin
      miscompares++;
      $display("FAIL bubble_valid got v=%b r=%b w=%b wb=%b exp 1 1 1 11", mem_valid, mem_mem_read, mem_mem_write, mem_wb);
    end
    ex_valid = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_v() || {mem_valid, mem_mem_read, mem_mem_write, mem_wb, mem_alu_result, mem_rd} !== '0) begin
      miscompares++;
      $display("FAIL bubble_gate got %h exp all-zero payload", obs);
    end
    ex_m = 3'b000;
    ex_wb = 2'b00;
  endtask
  task automatic test_reset_full();
    mem_ready = 1'b0;
    send(32'h3, 5'd3);
    tick();
    send(32'h4, 5'd4);
    tick();
    startin = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_v() || occupancy !== 2'd0 || mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_full got occ=%0d v=%b exp occ=0 v=0", occupancy, mem_valid);
    end
    startin = 1'b1;
    send(32'hE, 5'd14);
    tick();
    vectors++;
    if (obs !== exp_v() || mem_valid !== 1'b1 || mem_alu_result !== 32'hE || occupancy !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_full_next got v=%b alu=%h occ=%0d exp v=1 alu=e occ=1", mem_valid, mem_alu_result, occupancy);
    end
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      startin = $urandom_range(0, 24) != 0;
      flush = $urandom_range(0, 14) == 0;
      ex_valid = $urandom_range(0, 3) != 0;
      mem_ready = $urandom_range(0, 2) != 0;
      ex_wb = 2'($urandom);
      ex_m = 3'($urandom);
      ex_alu_result = $urandom;
      ex_store_data = $urandom;
      ex_rd = 5'($urandom);
      tick();
      vectors++;
      if (obs !== exp_v()) begin
        miscompares++;
        $display("FAIL random[%0d] got %h exp %h", i, obs, exp_v());
      end
    end
    startin = 1'b1;
    flush = 1'b0;
    ex_valid = 1'b0;
  endtask
  initial begin
    {startin, flush, ex_valid, mem_ready, ex_wb, ex_m, ex_alu_result, ex_store_data, ex_rd} = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_bubble();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
